// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus the IF/ID pipeline register for the 16-bit core.
//
// Ports
//   clk           core clock, rising edge
//   rst           asynchronous active-low reset
//   hazard_or_no  stall from the hazard unit (1 = hold pc and IF/ID)
//   flush         redirect from execute (squash IF/ID, load pc from flush_pc)
//   flush_pc      redirect target
//   imem_req      instruction memory request
//   imem_addr     request address
//   imem_rdy      memory accepted the request and returned data this cycle
//   imem_data     instruction word, valid when imem_req & imem_rdy
//   instr_dec     IF/ID instruction
//   pc_plus2_dec  IF/ID pc+2 of instr_dec
//   valid_dec     instr_dec is a real instruction (0 = bubble)
//   fetch_halted  a HALT reached IF/ID and fetching has stopped
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | requesting the word at pc
// S_HOLD   | word fetched under a stall is parked in the skid register
// S_DROP   | request squashed by a flush is still outstanding
// S_HALTED | HALT sits in IF/ID; no requests until a flush or reset

module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_or_no,
    input  logic        flush,
    input  logic [15:0] flush_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_dec,
    output logic [15:0] pc_plus2_dec,
    output logic        valid_dec,
    output logic        fetch_halted
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] skid_q, skid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp2_q, pcp2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic        accept;
    logic [15:0] pc_inc;

    assign accept = req_q & imem_rdy;
    assign pc_inc = pc_q + 16'd2;   // wraps modulo 2^16

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        skid_d   = skid_q;
        instr_d  = instr_q;
        pcp2_d   = pcp2_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        if (flush) begin
            pc_d     = flush_pc;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            // An unanswered request must stay on the bus until rdy, so its
            // req/addr are kept and the returned word is thrown away in S_DROP.
            if (req_q && !imem_rdy) begin
                state_d = S_DROP;
            end else begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = flush_pc;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (accept) begin
                        pc_d = pc_inc;
                        if (hazard_or_no) begin
                            skid_d  = imem_data;
                            state_d = S_HOLD;
                            req_d   = 1'b0;
                        end else begin
                            instr_d = imem_data;
                            pcp2_d  = pc_inc;
                            valid_d = 1'b1;
                            if (imem_data[15:11] == HALT_OP) begin
                                state_d  = S_HALTED;
                                halted_d = 1'b1;
                                req_d    = 1'b0;
                            end else begin
                                req_d  = 1'b1;
                                addr_d = pc_inc;
                            end
                        end
                    end else begin
                        // Outstanding request already has addr == pc, so this
                        // keeps it stable; otherwise it raises a new one.
                        req_d  = 1'b1;
                        addr_d = pc_q;
                        if (!hazard_or_no) begin
                            instr_d = NOP_INSTR;
                            valid_d = 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hazard_or_no) begin
                        instr_d = skid_q;
                        pcp2_d  = pc_q;
                        valid_d = 1'b1;
                        if (skid_q[15:11] == HALT_OP) begin
                            state_d  = S_HALTED;
                            halted_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                            req_d   = 1'b1;
                            addr_d  = pc_q;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_rdy) begin
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            skid_q   <= NOP_INSTR;
            instr_q  <= NOP_INSTR;
            pcp2_q   <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            skid_q   <= skid_d;
            instr_q  <= instr_d;
            pcp2_q   <= pcp2_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr_dec    = instr_q;
    assign pc_plus2_dec = pcp2_q;
    assign valid_dec    = valid_q;
    assign fetch_halted = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        hazard_or_no;
    logic        flush;
    logic [15:0] flush_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'hDEAD;
    logic [15:0] instr_dec;
    logic [15:0] pc_plus2_dec;
    logic        valid_dec;
    logic        fetch_halted;

    fetch_stage dut (
        .clk(clk), .rst(rst), .hazard_or_no(hazard_or_no), .flush(flush),
        .flush_pc(flush_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .instr_dec(instr_dec),
        .pc_plus2_dec(pc_plus2_dec), .valid_dec(valid_dec), .fetch_halted(fetch_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    int          lat = 1;
    logic        halt_en = 1'b0;
    logic [15:0] halt_addr = 16'h0020;
    int          mem_cnt = 0;

    function automatic logic [15:0] word(input logic [15:0] a);
        if (halt_en && a == halt_addr) return 16'h0000;
        return a ^ 16'hA5A0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Variable-latency memory: rdy on the lat-th cycle a request is held.
    always @(negedge clk) begin
        if (imem_rdy || !imem_req) mem_cnt = 0;
        if (imem_req) begin
            mem_cnt++;
            imem_rdy = (mem_cnt >= lat);
        end else begin
            imem_rdy = 1'b0;
        end
        imem_data = imem_rdy ? word(imem_addr) : 16'hDEAD;
    end

    // Scoreboard: decode consumes IF/ID on an edge with valid, no stall, no flush.
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcp2;
    } sb_t;
    sb_t  sb_q[$];
    logic sb_on = 1'b0;

    always @(negedge clk) begin
        if (sb_on && rst && valid_dec && !hazard_or_no && !flush) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_extra: got %h expected no instruction", instr_dec);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_instr", instr_dec, e.instr);
                chk("sb_pcp2", pc_plus2_dec, e.pcp2);
            end
        end
    end

    task automatic push_seq(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = start + 16'(2 * i);
            sb_q.push_back('{word(a), a + 16'd2});
        end
    endtask

    task automatic wait_sb(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        chk(name, 16'(sb_q.size()), 16'd0);
        sb_on = 1'b0;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b0;
        hazard_or_no = 1'b0;
        flush = 1'b0;
        flush_pc = 16'h0000;
        sb_on = 1'b0;
        sb_q.delete();
        halt_en = 1'b0;
        lat = l;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        fl;
        logic [15:0] fpc;
        logic        e_req;
        logic        c_addr;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic        c_pcp2;
        logic [15:0] e_pcp2;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0800,         1'b1, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, word(16'h0000),  1'b1, 16'h0002};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, word(16'h0000),  1'b1, 16'h0002};
        tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, word(16'h0000),  1'b1, 16'h0002};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, word(16'h0002),  1'b1, 16'h0004};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 1'b1, word(16'h0004),  1'b1, 16'h0006};
        tbl[6] = '{1'b1, 1'b1, 16'hFFFC, 1'b1, 1'b1, 16'hFFFC, 1'b0, 16'h0800,         1'b0, 16'h0000};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 1'b1, word(16'hFFFC),  1'b1, 16'hFFFE};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, word(16'hFFFE),  1'b1, 16'h0000};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, word(16'h0000),  1'b1, 16'h0002};

        // Reset values, during and right after reset.
        rst = 1'b0;
        hazard_or_no = 1'b0;
        flush = 1'b0;
        flush_pc = 16'h0000;
        #7;
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_instr", instr_dec, 16'h0800);
        chk("rst_pcp2", pc_plus2_dec, 16'h0000);
        chk("rst_valid", 16'(valid_dec), 16'd0);
        chk("rst_halted", 16'(fetch_halted), 16'd0);

        // Per-cycle trace with zero-wait memory: stall/skid, flush + accept, pc wrap.
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            hazard_or_no = tbl[i].stall;
            flush = tbl[i].fl;
            flush_pc = tbl[i].fpc;
            @(posedge clk);
            #2;
            chk($sformatf("tbl%0d_req", i), 16'(imem_req), 16'(tbl[i].e_req));
            if (tbl[i].c_addr) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 16'(valid_dec), 16'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_instr", i), instr_dec, tbl[i].e_instr);
            if (tbl[i].c_pcp2) chk($sformatf("tbl%0d_pcp2", i), pc_plus2_dec, tbl[i].e_pcp2);
        end

        // Zero-wait stream from RESET_PC.
        do_reset(1);
        push_seq(16'h0000, 3);
        sb_on = 1'b1;
        wait_sb("zw_drain", 20);

        // 3-cycle latency: address stable, two bubbles, then the word.
        do_reset(3);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lat3_req%0d", i), 16'(imem_req), 16'd1);
            chk($sformatf("lat3_addr%0d", i), imem_addr, 16'h0000);
            if (i > 0) begin
                chk($sformatf("lat3_bub_instr%0d", i), instr_dec, 16'h0800);
                chk($sformatf("lat3_bub_valid%0d", i), 16'(valid_dec), 16'd0);
            end
        end
        push_seq(16'h0000, 2);
        sb_on = 1'b1;
        wait_sb("lat3_drain", 20);

        // Two-cycle stall coinciding with an accept: word comes back from skid.
        do_reset(1);
        push_seq(16'h0000, 5);
        sb_on = 1'b1;
        repeat (3) @(posedge clk);
        #2 hazard_or_no = 1'b1;
        repeat (2) @(posedge clk);
        #2 hazard_or_no = 1'b0;
        wait_sb("stall_drain", 20);

        // Flush while the latency-3 request to 0x0010 is pending.
        do_reset(3);
        push_seq(16'h0000, 8);
        sb_on = 1'b1;
        wait_sb("pre_flush_drain", 60);
        chk("pre_flush_addr", imem_addr, 16'h0010);
        flush = 1'b1;
        flush_pc = 16'h0040;
        push_seq(16'h0040, 1);
        sb_on = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 16'(valid_dec), 16'd0);
        chk("flush_instr", instr_dec, 16'h0800);
        chk("drop_req", 16'(imem_req), 16'd1);
        chk("drop_addr", imem_addr, 16'h0010);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_addr == 16'h0040) break;
        end
        chk("redirect_addr", imem_addr, 16'h0040);
        wait_sb("flush_drain", 20);

        // HALT at 0x0020, then restart by flushing to 0x0000.
        do_reset(1);
        halt_en = 1'b1;
        push_seq(16'h0000, 17);
        sb_on = 1'b1;
        wait_sb("halt_drain", 40);
        chk("halted_set", 16'(fetch_halted), 16'd1);
        chk("halted_instr", instr_dec, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("halted_req%0d", k), 16'(imem_req), 16'd0);
        end
        #1 flush = 1'b1;
        flush_pc = 16'h0000;
        @(posedge clk);
        #2 flush = 1'b0;
        chk("resume_halted", 16'(fetch_halted), 16'd0);
        chk("resume_req", 16'(imem_req), 16'd1);
        chk("resume_addr", imem_addr, 16'h0000);
        push_seq(16'h0000, 2);
        sb_on = 1'b1;
        wait_sb("resume_drain", 20);
        halt_en = 1'b0;

        // Asynchronous reset mid-stall with the skid buffer full.
        do_reset(1);
        repeat (3) @(posedge clk);
        #2 hazard_or_no = 1'b1;
        repeat (2) @(posedge clk);
        #2 chk("skid_req", 16'(imem_req), 16'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 16'(imem_req), 16'd0);
        chk("arst_instr", instr_dec, 16'h0800);
        chk("arst_pcp2", pc_plus2_dec, 16'h0000);
        chk("arst_valid", 16'(valid_dec), 16'd0);
        chk("arst_halted", 16'(fetch_halted), 16'd0);
        hazard_or_no = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        push_seq(16'h0000, 2);
        sb_on = 1'b1;
        @(posedge clk);
        #2;
        chk("post_rst_req", 16'(imem_req), 16'd1);
        chk("post_rst_addr", imem_addr, 16'h0000);
        wait_sb("post_rst_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected end within 200000");
        $fatal(1, "timeout");
    end

endmodule
